multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS-subset CPU. It sequences the shared ALU, memory port, instruction register and register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It drives the 2-bit ALUOp consumed by the ALU control decoder:
- 00 add
- 01 sub
- 10 R-type funct
- 11 LUI / immediate path

It stalls on a single shared memory port via a ready handshake.

---
 rtl/multicycle_pkg.sv | 67 ++++++
 rtl/multicycle_opdec.sv | 32 +++
 rtl/multicycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM states, opcodes,
// ALUOp / ALUSrcB / PCSource codes and the bundled control-word struct.
package multicycle_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC_R   = 4'd2;
  localparam state_t S_EXEC_I   = 4'd3;
  localparam state_t S_EXEC_LUI = 4'd4;
  localparam state_t S_MEM_ADDR = 4'd5;
  localparam state_t S_MEM_RD   = 4'd6;
  localparam state_t S_MEM_WB   = 4'd7;
  localparam state_t S_MEM_WR   = 4'd8;
  localparam state_t S_ALU_WB   = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;
  localparam state_t S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       err;
  } ctrl_t;

  // States that own the shared memory port and may stall on mem_ready_i.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_opdec.sv
// Combinational opcode decoder: picks the state that follows DECODE and
// flags opcodes outside the supported subset.
module multicycle_opdec
  import multicycle_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output state_t         next_state,
  output logic           illegal
);

  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (opcode)
      OPW'(OP_RTYPE):       next_state = S_EXEC_R;
      OPW'(OP_ADDI):        next_state = S_EXEC_I;
      OPW'(OP_LUI):         next_state = S_EXEC_LUI;
      OPW'(OP_LW),
      OPW'(OP_SW):          next_state = S_MEM_ADDR;
      OPW'(OP_BEQ),
      OPW'(OP_BNE):         next_state = S_BRANCH;
      OPW'(OP_J):           next_state = S_JUMP;
      default: begin
        next_state = S_FETCH;
        illegal    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU; sequences ALU, memory,
// IR and register file, stalling on the shared memory port's ready handshake.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OPW           = 6,
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  input  logic           mem_ready_i,
  output logic           pc_write_o,
  output logic           pc_write_cond_o,
  output logic           branch_ne_o,
  output logic [1:0]     pc_source_o,
  output logic           i_or_d_o,
  output logic           mem_read_o,
  output logic           mem_write_o,
  output logic           ir_write_o,
  output logic           mem_to_reg_o,
  output logic           reg_write_o,
  output logic           reg_dst_o,
  output logic           alu_src_a_o,
  output logic [1:0]     alu_src_b_o,
  output logic [1:0]     alu_op_o,
  output logic           instr_done_o,
  output logic           err_o
);

  localparam int            CW      = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(FETCH_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(FETCH_TIMEOUT - 1);

  state_t          state_q;
  state_t          state_d;
  state_t          dec_state;
  logic            dec_illegal;
  logic [OPW-1:0]  op_q;
  logic            rtype_q;
  logic [CW-1:0]   wait_cnt;
  logic            waiting;
  logic            timeout_hit;
  ctrl_t           ctrl;
  ctrl_t           ctrl_out;

  // The branch comparison itself is done in the datapath; zero_i is not needed here.
  logic unused_zero;
  assign unused_zero = zero_i;

  multicycle_opdec #(.OPW(OPW)) u_opdec (
    .opcode     (opcode_i),
    .next_state (dec_state),
    .illegal    (dec_illegal)
  );

  assign waiting     = is_mem_state(state_q) && !mem_ready_i;
  assign timeout_hit = (FETCH_TIMEOUT != 0) && waiting && (wait_cnt == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE:   state_d = dec_state;
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (op_q == OPW'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Opcode is captured once in DECODE; later states never look at opcode_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= '0;
      rtype_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      op_q    <= opcode_i;
      rtype_q <= (opcode_i == OPW'(OP_RTYPE));
    end
  end

  // Saturating wait counter: fires err once per stalled memory state, never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if ((FETCH_TIMEOUT != 0) && waiting && (wait_cnt != TO_MAX)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.err        = dec_illegal;
        ctrl.instr_done = dec_illegal;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC_LUI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_IMM;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_dst    = rtype_q;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready_i;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = op_q[0];
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (timeout_hit) ctrl.err = 1'b1;
  end

  // Reset forces every control line low immediately, so nothing is written mid-reset.
  assign ctrl_out = rst_i ? '0 : ctrl;

  assign pc_write_o      = ctrl_out.pc_write;
  assign pc_write_cond_o = ctrl_out.pc_write_cond;
  assign branch_ne_o     = ctrl_out.branch_ne;
  assign pc_source_o     = ctrl_out.pc_source;
  assign i_or_d_o        = ctrl_out.i_or_d;
  assign mem_read_o      = ctrl_out.mem_read;
  assign mem_write_o     = ctrl_out.mem_write;
  assign ir_write_o      = ctrl_out.ir_write;
  assign mem_to_reg_o    = ctrl_out.mem_to_reg;
  assign reg_write_o     = ctrl_out.reg_write;
  assign reg_dst_o       = ctrl_out.reg_dst;
  assign alu_src_a_o     = ctrl_out.alu_src_a;
  assign alu_src_b_o     = ctrl_out.alu_src_b;
  assign alu_op_o        = ctrl_out.alu_op;
  assign instr_done_o    = ctrl_out.instr_done;
  assign err_o           = ctrl_out.err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences then random
// instructions with random memory stalls, checked cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TO = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum {P_FETCH, P_DECODE, P_EXR, P_EXI, P_EXLUI, P_MADDR,
                P_MRD, P_MWB, P_MWR, P_AWB, P_BR, P_J} ph_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       err;
  } ov_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o;
  logic       mem_write_o, ir_write_o, mem_to_reg_o, reg_write_o, reg_dst_o;
  logic       alu_src_a_o, instr_done_o, err_o;
  logic [1:0] pc_source_o, alu_src_b_o, alu_op_o;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  ov_t obs;

  multicycle_ctrl #(.OPW(6), .FETCH_TIMEOUT(TO)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .opcode_i        (opcode_i),
    .zero_i          (zero_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .branch_ne_o     (branch_ne_o),
    .pc_source_o     (pc_source_o),
    .i_or_d_o        (i_or_d_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_write_o     (reg_write_o),
    .reg_dst_o       (reg_dst_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .instr_done_o    (instr_done_o),
    .err_o           (err_o)
  );

  assign obs = {pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o, i_or_d_o,
                mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_write_o,
                reg_dst_o, alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o, err_o};

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic legal(input logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  // Expected control word for one cycle of an instruction step.
  // k is the 1-based index of a stalled memory cycle (0 on the ready cycle).
  function automatic ov_t expv(input ph_t ph, input logic [5:0] op, input logic rdy, input int k);
    ov_t e = '0;
    case (ph)
      P_FETCH: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        e.ir_write = rdy;  e.pc_write  = rdy;
        e.err      = !rdy && (k == TO);
      end
      P_DECODE: begin
        e.alu_src_b  = 2'b11;
        e.err        = !legal(op);
        e.instr_done = !legal(op);
      end
      P_EXR:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 2'b10; end
      P_EXI:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b00; end
      P_EXLUI: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
      P_MADDR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b00; end
      P_AWB: begin
        e.reg_write = 1'b1; e.reg_dst = (op == OP_R); e.instr_done = 1'b1;
      end
      P_MRD: begin
        e.mem_read = 1'b1; e.i_or_d = 1'b1; e.err = !rdy && (k == TO);
      end
      P_MWB: begin
        e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
      end
      P_MWR: begin
        e.mem_write = 1'b1; e.i_or_d = 1'b1; e.instr_done = rdy;
        e.err = !rdy && (k == TO);
      end
      P_BR: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 2'b01;
        e.pc_write_cond = 1'b1; e.pc_source = 2'b01; e.branch_ne = op[0];
        e.instr_done = 1'b1;
      end
      P_J: begin
        e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input ov_t e, input string tag);
    tests++;
    assert (obs === e) else begin
      failed++;
      $error("FAIL %s cyc=%0d: observed %b required %b", tag, cyc, obs, e);
    end
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic step(input ov_t e, input logic [5:0] opd, input logic rdy, input string tag);
    opcode_i    = opd;
    mem_ready_i = rdy;
    zero_i      = 1'($urandom);
    @(negedge clk_i);
    check(e, tag);
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_phase(input ph_t ph, input logic [5:0] op, input int w, input string tag);
    for (int k = 1; k <= w; k++) step(expv(ph, op, 1'b0, k), rnd_op(), 1'b0, tag);
    step(expv(ph, op, 1'b1, 0), rnd_op(), 1'b1, tag);
  endtask

  task automatic do_instr(input logic [5:0] op, input int wf, input int wm);
    mem_phase(P_FETCH, op, wf, "fetch");
    step(expv(P_DECODE, op, 1'b0, 0), op, 1'($urandom), "decode");
    case (op)
      OP_R: begin
        step(expv(P_EXR, op, 1'b0, 0), rnd_op(), 1'($urandom), "exec_r");
        step(expv(P_AWB, op, 1'b0, 0), rnd_op(), 1'($urandom), "alu_wb_r");
      end
      OP_ADDI: begin
        step(expv(P_EXI, op, 1'b0, 0), rnd_op(), 1'($urandom), "exec_i");
        step(expv(P_AWB, op, 1'b0, 0), rnd_op(), 1'($urandom), "alu_wb_i");
      end
      OP_LUI: begin
        step(expv(P_EXLUI, op, 1'b0, 0), rnd_op(), 1'($urandom), "exec_lui");
        step(expv(P_AWB, op, 1'b0, 0), rnd_op(), 1'($urandom), "alu_wb_lui");
      end
      OP_LW: begin
        step(expv(P_MADDR, op, 1'b0, 0), rnd_op(), 1'($urandom), "mem_addr_lw");
        mem_phase(P_MRD, op, wm, "mem_rd");
        step(expv(P_MWB, op, 1'b0, 0), rnd_op(), 1'($urandom), "mem_wb");
      end
      OP_SW: begin
        step(expv(P_MADDR, op, 1'b0, 0), rnd_op(), 1'($urandom), "mem_addr_sw");
        mem_phase(P_MWR, op, wm, "mem_wr");
      end
      OP_BEQ, OP_BNE: step(expv(P_BR, op, 1'b0, 0), rnd_op(), 1'($urandom), "branch");
      OP_J:           step(expv(P_J, op, 1'b0, 0), rnd_op(), 1'($urandom), "jump");
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{OP_R, OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};

    rst_i = 1'b1; opcode_i = '0; mem_ready_i = 1'b1; zero_i = 1'b0;
    @(negedge clk_i);
    check('0, "reset_hold");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    do_instr(OP_R,    0, 0);
    do_instr(OP_LW,   0, 2);
    do_instr(OP_BNE,  0, 0);
    do_instr(OP_LUI,  0, 0);
    do_instr(OP_J,    0, 0);
    do_instr(6'b111111, 0, 0);
    do_instr(OP_BEQ,  1, 0);
    do_instr(OP_SW,   0, 1);
    do_instr(OP_ADDI, 2, 0);
    do_instr(OP_R,    5, 0);
    do_instr(OP_LW,   0, 4);
    do_instr(OP_SW,   3, 3);

    // Reset asserted while a store is stalled.
    mem_phase(P_FETCH, OP_SW, 0, "fetch");
    step(expv(P_DECODE, OP_SW, 1'b0, 0), OP_SW, 1'b1, "decode");
    step(expv(P_MADDR, OP_SW, 1'b0, 0), rnd_op(), 1'b0, "mem_addr_sw");
    step(expv(P_MWR, OP_SW, 1'b0, 1), rnd_op(), 1'b0, "mem_wr_wait");
    #1 rst_i = 1'b1;
    #1 check('0, "reset_async");
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    check('0, "reset_ready_ignored");
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    step(expv(P_FETCH, OP_J, 1'b1, 0), rnd_op(), 1'b1, "post_reset_fetch");
    step(expv(P_DECODE, OP_J, 1'b0, 0), OP_J, 1'b0, "decode");
    step(expv(P_J, OP_J, 1'b0, 0), rnd_op(), 1'b1, "jump");

    for (int n = 0; n < 200; n++) begin
      int pick;
      int wf;
      int wm;
      pick = $urandom_range(0, 9);
      op   = (pick < 8) ? ops[pick] : rnd_op();
      wf   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      wm   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      do_instr(op, wf, wm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
